ddr3_avl_arb2: RTL and testbench

- Two-port arbiter sharing one DDR3 Avalon-MM local interface: 26-bit word address, 64-bit data, 2-bit burst size, 8 byte enables.
- Sits between two requesters (e.g. stream write engine and readback engine) and the DDR3 controller.
- Round-robin command arbitration; a granted write burst holds the grant until its last beat.
- Read-return routing through an in-order tag FIFO.

---
 rtl/ddr3_avl_arb2.sv | 211 +++++++++++++++++++++
 tb/tb_ddr3_avl_arb2.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_arb2.sv
// rtl/ddr3_avl_arb2.sv - two-port round-robin arbiter onto one DDR3 Avalon-MM local interface
// Write bursts keep the grant until their last beat; read returns are steered by an in-order tag FIFO.
module ddr3_avl_arb2 #(
  parameter int TAG_DEPTH = 16,
  parameter int TAG_AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] p0_addr,
  input  logic [1:0]  p0_size,
  input  logic [63:0] p0_wdata,
  input  logic [7:0]  p0_be,
  input  logic        p0_write_req,
  input  logic        p0_read_req,
  output logic        p0_ready,
  output logic [63:0] p0_rdata,
  output logic        p0_rdata_valid,
  input  logic [25:0] p1_addr,
  input  logic [1:0]  p1_size,
  input  logic [63:0] p1_wdata,
  input  logic [7:0]  p1_be,
  input  logic        p1_write_req,
  input  logic        p1_read_req,
  output logic        p1_ready,
  output logic [63:0] p1_rdata,
  output logic        p1_rdata_valid,
  input  logic        avl_ready,
  output logic [25:0] avl_addr,
  output logic [1:0]  avl_size,
  output logic [63:0] avl_wdata,
  output logic [7:0]  avl_be,
  output logic        avl_write_req,
  output logic        avl_read_req,
  output logic        avl_burstbegin,
  input  logic [63:0] avl_rdata,
  input  logic        avl_rdata_valid,
  output logic        rd_orphan
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_WBURST = 2'd2;
  localparam logic [TAG_AW:0] L_FULL = (TAG_AW+1)'(TAG_DEPTH);

  logic [1:0]        r_state;
  logic              r_gnt;
  logic              r_rr_last;
  logic [1:0]        r_beats;
  logic [1:0]        r_bcnt;
  logic [25:0]       r_laddr;
  logic [1:0]        r_lsize;
  logic [2:0]        r_tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] r_wp;
  logic [TAG_AW-1:0] r_rp;
  logic [TAG_AW:0]   r_cnt;
  logic [1:0]        r_ret_cnt;
  logic              r_orphan;

  logic [25:0] w_g_addr;
  logic [1:0]  w_g_size;
  logic [63:0] w_g_wdata;
  logic [7:0]  w_g_be;
  logic        w_g_wr;
  logic        w_g_rd;
  logic [1:0]  w_g_beats;
  logic        w_g_ready;
  logic        w_full;
  logic        w_empty;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_any;
  logic        w_pick;
  logic        w_rd_acc;
  logic [2:0]  w_head;
  logic        w_ret;
  logic        w_pop;

  assign w_g_addr  = r_gnt ? p1_addr      : p0_addr;
  assign w_g_size  = r_gnt ? p1_size      : p0_size;
  assign w_g_wdata = r_gnt ? p1_wdata     : p0_wdata;
  assign w_g_be    = r_gnt ? p1_be        : p0_be;
  assign w_g_wr    = r_gnt ? p1_write_req : p0_write_req;
  assign w_g_rd    = r_gnt ? p1_read_req  : p0_read_req;
  assign w_g_beats = (w_g_size == 2'd0) ? 2'd1 : w_g_size;

  assign w_full  = (r_cnt == L_FULL);
  assign w_empty = (r_cnt == '0);
  assign w_elig0 = p0_write_req | (p0_read_req & ~w_full);
  assign w_elig1 = p1_write_req | (p1_read_req & ~w_full);
  assign w_any   = w_elig0 | w_elig1;
  // On a tie the port that did not win last time goes next.
  assign w_pick  = (w_elig0 & w_elig1) ? ~r_rr_last : w_elig1;

  always_comb begin
    avl_addr       = '0;
    avl_size       = '0;
    avl_wdata      = '0;
    avl_be         = '0;
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b0;
    avl_burstbegin = 1'b0;
    w_g_ready      = 1'b0;
    if (!reset) begin
      case (r_state)
        S_GRANT: begin
          avl_addr       = w_g_addr;
          avl_size       = w_g_size;
          avl_wdata      = w_g_wdata;
          avl_be         = w_g_be;
          avl_write_req  = w_g_wr;
          avl_read_req   = w_g_rd & ~w_g_wr;
          avl_burstbegin = w_g_wr | w_g_rd;
          w_g_ready      = avl_ready & (w_g_wr | w_g_rd);
        end
        S_WBURST: begin
          avl_addr      = r_laddr;
          avl_size      = r_lsize;
          avl_wdata     = w_g_wdata;
          avl_be        = w_g_be;
          avl_write_req = w_g_wr;
          w_g_ready     = avl_ready & w_g_wr;
        end
        default: ;
      endcase
    end
  end

  assign p0_ready = w_g_ready & ~r_gnt;
  assign p1_ready = w_g_ready & r_gnt;
  assign w_rd_acc = (r_state == S_GRANT) & w_g_ready & ~w_g_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_rr_last <= 1'b1;
      r_beats   <= 2'd0;
      r_bcnt    <= 2'd0;
      r_laddr   <= '0;
      r_lsize   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_pick;
            r_rr_last <= w_pick;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_g_ready) begin
            if (w_g_wr) begin
              r_beats <= w_g_beats;
              r_bcnt  <= 2'd1;
              r_laddr <= w_g_addr;
              r_lsize <= w_g_size;
              r_state <= (w_g_beats == 2'd1) ? S_IDLE : S_WBURST;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (!w_g_wr && !w_g_rd) begin
            // Requester withdrew before acceptance: give the bus back rather than hang.
            r_state <= S_IDLE;
          end
        end
        S_WBURST: begin
          if (w_g_ready) begin
            r_bcnt <= r_bcnt + 2'd1;
            if ((r_bcnt + 2'd1) == r_beats) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_head = r_tag_mem[r_rp];
  assign w_ret  = avl_rdata_valid & ~w_empty;
  assign w_pop  = w_ret & ((r_ret_cnt + 2'd1) == w_head[1:0]);

  always_ff @(posedge clk) begin
    if (w_rd_acc) r_tag_mem[r_wp] <= {r_gnt, w_g_beats};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_ret_cnt <= 2'd0;
      r_orphan  <= 1'b0;
    end else begin
      if (w_rd_acc) r_wp <= r_wp + TAG_AW'(1);
      if (w_pop)    r_rp <= r_rp + TAG_AW'(1);
      case ({w_rd_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + (TAG_AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (TAG_AW+1)'(1);
        default: ;
      endcase
      if (w_ret) r_ret_cnt <= w_pop ? 2'd0 : r_ret_cnt + 2'd1;
      if (avl_rdata_valid && w_empty) r_orphan <= 1'b1;
    end
  end

  assign p0_rdata       = reset ? '0 : avl_rdata;
  assign p1_rdata       = reset ? '0 : avl_rdata;
  assign p0_rdata_valid = w_ret & ~w_head[2] & ~reset;
  assign p1_rdata_valid = w_ret & w_head[2] & ~reset;
  assign rd_orphan      = r_orphan & ~reset;

endmodule

// File: tb/tb_ddr3_avl_arb2.sv
// tb/tb_ddr3_avl_arb2.sv - directed scenarios plus randomized traffic against a transaction-level model
module tb_ddr3_avl_arb2;

  localparam int NTX = 40;

  typedef struct {
    bit          wr;
    logic [25:0] addr;
    logic [1:0]  size;
    logic [191:0] d;
    logic [23:0] be;
  } txn_t;

  typedef struct {
    int port;
    int beats;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [25:0] pa [2];
  logic [1:0]  ps [2];
  logic [63:0] pd [2];
  logic [7:0]  pb [2];
  logic        pw [2];
  logic        pr [2];

  logic [25:0] p0_addr, p1_addr;
  logic [1:0]  p0_size, p1_size;
  logic [63:0] p0_wdata, p1_wdata;
  logic [7:0]  p0_be, p1_be;
  logic        p0_write_req, p1_write_req, p0_read_req, p1_read_req;
  logic        p0_ready, p1_ready, p0_rdata_valid, p1_rdata_valid;
  logic [63:0] p0_rdata, p1_rdata;
  logic        avl_ready;
  logic [25:0] avl_addr;
  logic [1:0]  avl_size;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic        avl_write_req, avl_read_req, avl_burstbegin;
  logic [63:0] avl_rdata;
  logic        avl_rdata_valid;
  logic        rd_orphan;

  assign p0_addr = pa[0];  assign p1_addr = pa[1];
  assign p0_size = ps[0];  assign p1_size = ps[1];
  assign p0_wdata = pd[0]; assign p1_wdata = pd[1];
  assign p0_be = pb[0];    assign p1_be = pb[1];
  assign p0_write_req = pw[0]; assign p1_write_req = pw[1];
  assign p0_read_req = pr[0];  assign p1_read_req = pr[1];

  ddr3_avl_arb2 #(.TAG_DEPTH(16), .TAG_AW(4)) dut (
    .clk(clk), .reset(reset),
    .p0_addr(p0_addr), .p0_size(p0_size), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_write_req(p0_write_req), .p0_read_req(p0_read_req), .p0_ready(p0_ready),
    .p0_rdata(p0_rdata), .p0_rdata_valid(p0_rdata_valid),
    .p1_addr(p1_addr), .p1_size(p1_size), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_write_req(p1_write_req), .p1_read_req(p1_read_req), .p1_ready(p1_ready),
    .p1_rdata(p1_rdata), .p1_rdata_valid(p1_rdata_valid),
    .avl_ready(avl_ready), .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_write_req(avl_write_req),
    .avl_read_req(avl_read_req), .avl_burstbegin(avl_burstbegin),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid), .rd_orphan(rd_orphan)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  txn_t tx [2][NTX];
  rd_t  oq [$];
  int   idx [2];
  int   beat [2];
  bit   present [2];
  int   cyc, last_end, rc, cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      pa[p] = '0; ps[p] = '0; pd[p] = '0; pb[p] = '0; pw[p] = 1'b0; pr[p] = 1'b0;
    end
    avl_ready = 1'b1;
    avl_rdata = '0;
    avl_rdata_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1; clear_inputs(); look();
    chk("rst_wr", avl_write_req, 0);
    chk("rst_rd", avl_read_req, 0);
    chk("rst_orphan", rd_orphan, 0);
    tick(); reset = 1'b0; look();
    chk("post_rst_rdy", {p0_ready, p1_ready}, 0);
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == 2'd0) ? 1 : int'(s);
  endfunction

  function automatic logic rdy(input int p);
    return (p == 0) ? p0_ready : p1_ready;
  endfunction

  task automatic drive_port(input int p);
    txn_t t;
    if (idx[p] >= NTX) begin
      pw[p] = 1'b0; pr[p] = 1'b0;
      return;
    end
    t = tx[p][idx[p]];
    if (!present[p] && $urandom_range(0, 2) != 0) present[p] = 1'b1;
    pw[p] = present[p] & t.wr;
    pr[p] = present[p] & !t.wr;
    // Address and size are scrambled after the first beat to prove they are latched.
    pa[p] = (beat[p] == 0) ? t.addr : 26'($urandom);
    ps[p] = (beat[p] == 0) ? t.size : 2'($urandom);
    pd[p] = t.d[beat[p]*64 +: 64];
    pb[p] = t.be[beat[p]*8 +: 8];
  endtask

  initial begin
    txn_t t;
    rd_t  r;
    bit   busy [2];
    reset = 1'b1;
    clear_inputs();
    do_reset();

    // p0 two-beat write
    tick(); pa[0] = 26'h100; ps[0] = 2'd2; pd[0] = 64'h1111111111111111; pb[0] = 8'hff; pw[0] = 1'b1; look();
    chk("t1_idle_wr", avl_write_req, 0);
    chk("t1_idle_rdy", p0_ready, 0);
    tick(); look();
    chk("t1_b0_wr", avl_write_req, 1);
    chk("t1_b0_bb", avl_burstbegin, 1);
    chk("t1_b0_addr", avl_addr, 26'h100);
    chk("t1_b0_data", avl_wdata, 64'h1111111111111111);
    chk("t1_b0_rdy", p0_ready, 1);
    tick(); pd[0] = 64'h2222222222222222; look();
    chk("t1_b1_wr", avl_write_req, 1);
    chk("t1_b1_bb", avl_burstbegin, 0);
    chk("t1_b1_addr", avl_addr, 26'h100);
    chk("t1_b1_size", avl_size, 2);
    chk("t1_b1_data", avl_wdata, 64'h2222222222222222);
    chk("t1_b1_rdy", p0_ready, 1);
    tick(); pw[0] = 1'b0; look();
    chk("t1_done_wr", avl_write_req, 0);

    // simultaneous reads: p0 first, then p1, returns routed in order
    do_reset();
    tick(); pa[0] = 26'h10; ps[0] = 2'd1; pr[0] = 1'b1; pa[1] = 26'h20; ps[1] = 2'd1; pr[1] = 1'b1; look();
    chk("t2_idle_rdy", {p0_ready, p1_ready}, 0);
    tick(); look();
    chk("t2_g0_rdy", {p0_ready, p1_ready}, 2'b10);
    chk("t2_g0_rd", avl_read_req, 1);
    chk("t2_g0_bb", avl_burstbegin, 1);
    chk("t2_g0_addr", avl_addr, 26'h10);
    tick(); pr[0] = 1'b0; look();
    chk("t2_bubble", {p0_ready, p1_ready, avl_read_req}, 0);
    tick(); look();
    chk("t2_g1_rdy", {p0_ready, p1_ready}, 2'b01);
    chk("t2_g1_addr", avl_addr, 26'h20);
    tick(); pr[1] = 1'b0; avl_rdata_valid = 1'b1; avl_rdata = 64'hA5A5000000000001; look();
    chk("t2_ret0_v", {p0_rdata_valid, p1_rdata_valid}, 2'b10);
    chk("t2_ret0_d", p0_rdata, 64'hA5A5000000000001);
    tick(); avl_rdata = 64'h5A5A000000000002; look();
    chk("t2_ret1_v", {p0_rdata_valid, p1_rdata_valid}, 2'b01);
    chk("t2_ret1_d", p1_rdata, 64'h5A5A000000000002);
    tick(); avl_rdata_valid = 1'b0; look();
    chk("t2_orphan", rd_orphan, 0);

    // write burst stalled by avl_ready keeps the grant
    do_reset();
    tick(); pa[0] = 26'h400; ps[0] = 2'd3; pd[0] = 64'hE0; pw[0] = 1'b1;
    pa[1] = 26'h500; ps[1] = 2'd1; pr[1] = 1'b1; look();
    chk("t3_idle", {p0_ready, p1_ready}, 0);
    tick(); look();
    chk("t3_b0", {p0_ready, p1_ready}, 2'b10);
    chk("t3_b0_addr", avl_addr, 26'h400);
    tick(); pd[0] = 64'hE1; avl_ready = 1'b0; look();
    chk("t3_stall0", {p0_ready, p1_ready}, 0);
    chk("t3_stall_wr", avl_write_req, 1);
    for (int i = 1; i < 3; i++) begin
      tick(); look();
      chk("t3_stall", {p0_ready, p1_ready, avl_read_req}, 0);
    end
    tick(); avl_ready = 1'b1; look();
    chk("t3_b1", {p0_ready, p1_ready}, 2'b10);
    chk("t3_b1_data", avl_wdata, 64'hE1);
    tick(); pd[0] = 64'hE2; look();
    chk("t3_b2", {p0_ready, p1_ready}, 2'b10);
    chk("t3_b2_addr", avl_addr, 26'h400);
    tick(); pw[0] = 1'b0; look();
    chk("t3_bubble", {p1_ready, avl_read_req}, 0);
    tick(); look();
    chk("t3_p1_rdy", p1_ready, 1);
    chk("t3_p1_rd", avl_read_req, 1);
    chk("t3_p1_addr", avl_addr, 26'h500);
    tick(); pr[1] = 1'b0; look();

    // tag FIFO full blocks the 17th read until a pop
    do_reset();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin pa[1] = 26'h777; ps[1] = 2'd1; pr[1] = 1'b1; end
      look();
      if (p1_ready) cnt++;
    end
    chk("t4_granted", cnt, 16);
    tick(); avl_rdata_valid = 1'b1; avl_rdata = 64'h1234; look();
    chk("t4_pop_v", {p0_rdata_valid, p1_rdata_valid}, 2'b01);
    chk("t4_pop_rdy", p1_ready, 0);
    tick(); avl_rdata_valid = 1'b0; look();
    chk("t4_wait_rdy", p1_ready, 0);
    tick(); look();
    chk("t4_regrant", p1_ready, 1);
    tick(); pr[1] = 1'b0; look();

    // orphan return
    do_reset();
    tick(); avl_rdata_valid = 1'b1; avl_rdata = 64'hDEAD; look();
    chk("t5_orphan_v", {p0_rdata_valid, p1_rdata_valid}, 0);
    tick(); avl_rdata_valid = 1'b0; look();
    chk("t5_orphan_set", rd_orphan, 1);
    do_reset();
    chk("t5_orphan_clr", rd_orphan, 0);

    // reset in the middle of a burst
    tick(); pa[0] = 26'h200; ps[0] = 2'd3; pd[0] = 64'hB0; pw[0] = 1'b1; look();
    tick(); look();
    chk("t6_b0", p0_ready, 1);
    tick(); pd[0] = 64'hB1; reset = 1'b1; look();
    chk("t6_rst_wr", avl_write_req, 0);
    chk("t6_rst_rdy", p0_ready, 0);
    tick(); reset = 1'b0; pw[0] = 1'b0; pa[1] = 26'h300; ps[1] = 2'd1; pd[1] = 64'hC0; pw[1] = 1'b1; look();
    chk("t6_idle_wr", avl_write_req, 0);
    chk("t6_idle_rdy", p1_ready, 0);
    tick(); look();
    chk("t6_new_wr", avl_write_req, 1);
    chk("t6_new_bb", avl_burstbegin, 1);
    chk("t6_new_addr", avl_addr, 26'h300);
    chk("t6_new_rdy", {p0_ready, p1_ready}, 2'b01);
    tick(); pw[1] = 1'b0; look();

    // randomized traffic
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NTX; i++) begin
        tx[p][i].wr   = 1'($urandom_range(0, 1));
        tx[p][i].addr = 26'($urandom);
        tx[p][i].size = 2'($urandom_range(0, 3));
        tx[p][i].d    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tx[p][i].be   = 24'($urandom);
      end
      idx[p] = 0; beat[p] = 0; present[p] = 1'b0;
    end
    cyc = 0; last_end = -10; rc = 0;
    while ((idx[0] < NTX || idx[1] < NTX || oq.size() > 0) && cyc < 8000) begin
      tick();
      avl_ready = ($urandom_range(0, 3) != 0);
      if (oq.size() > 0 && $urandom_range(0, 2) == 0) begin
        avl_rdata_valid = 1'b1;
        avl_rdata = {$urandom, $urandom};
      end else begin
        avl_rdata_valid = 1'b0;
      end
      for (int p = 0; p < 2; p++) drive_port(p);
      look();
      cyc++;

      if (avl_rdata_valid) begin
        r = oq[0];
        chk("rnd_rv0", p0_rdata_valid, r.port == 0);
        chk("rnd_rv1", p1_rdata_valid, r.port == 1);
        chk("rnd_rd0", p0_rdata, avl_rdata);
        chk("rnd_rd1", p1_rdata, avl_rdata);
        rc++;
        if (rc == r.beats) begin
          void'(oq.pop_front());
          rc = 0;
        end
      end else begin
        chk("rnd_rv_idle", {p0_rdata_valid, p1_rdata_valid}, 0);
      end

      for (int p = 0; p < 2; p++)
        busy[p] = (idx[p] < NTX) && tx[p][idx[p]].wr && (beat[p] > 0);
      chk("rnd_interleave", (p0_ready & busy[1]) | (p1_ready & busy[0]), 0);

      for (int p = 0; p < 2; p++) begin
        chk("rnd_rdy_noreq", rdy(p) & ~present[p], 0);
        if (rdy(p) && present[p]) begin
          t = tx[p][idx[p]];
          if (beat[p] == 0) chk("rnd_bubble", (cyc - last_end) >= 2, 1);
          chk("rnd_addr", avl_addr, t.addr);
          chk("rnd_size", avl_size, t.size);
          if (t.wr) begin
            chk("rnd_wr", {avl_write_req, avl_read_req}, 2'b10);
            chk("rnd_wbb", avl_burstbegin, beat[p] == 0);
            chk("rnd_wdata", avl_wdata, t.d[beat[p]*64 +: 64]);
            chk("rnd_wbe", avl_be, t.be[beat[p]*8 +: 8]);
            beat[p]++;
            if (beat[p] == nb(t.size)) begin
              idx[p]++;
              beat[p] = 0;
              last_end = cyc;
            end
          end else begin
            chk("rnd_rd", {avl_write_req, avl_read_req}, 2'b01);
            chk("rnd_rbb", avl_burstbegin, 1);
            r.port = p;
            r.beats = nb(t.size);
            oq.push_back(r);
            idx[p]++;
            last_end = cyc;
          end
          present[p] = 1'b0;
        end
      end
    end
    chk("rnd_complete", (idx[0] == NTX) && (idx[1] == NTX) && (oq.size() == 0), 1);
    chk("rnd_orphan", rd_orphan, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
